// File: rtl/oam_dma_controller_pkg.sv
// Shared types and addresses for the OAM DMA controller.
// Holds the FSM state encoding and the source-page remap helper.
package oam_dma_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    READ,
    LATCH,
    WRITE
  } dma_state_t;

  localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
  localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;

  // Pages above 0xDF are the echo of work RAM, so they fold back by 0x20.
  function automatic logic [7:0] remap_page(input logic [7:0] page);
    return (page > 8'hDF) ? (page - 8'h20) : page;
  endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer and CPU/DMA arbiter for the single memoryunit port.
// Copies LENGTH bytes from {src_q, index} to OAM_BASE + index, three cycles per byte.
//
// state | meaning
// IDLE  | no transfer, CPU owns the memory port
// START | transfer accepted, index cleared
// READ  | source byte address issued with mem_oe
// LATCH | source byte captured from mem_rdata
// WRITE | byte written to OAM, then advance or finish
module oam_dma_controller
  import oam_dma_controller_pkg::*;
#(
  parameter logic [15:0] DMA_REG  = DMA_REG_ADDR,
  parameter logic [15:0] OAM_BASE = OAM_BASE_ADDR,
  parameter int          LENGTH   = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_wdata,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        cpu_blocked,
  output logic        dma_active,
  output logic [7:0]  dma_index
);

  localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

  dma_state_t state, state_next;
  logic [7:0] index;
  logic [7:0] src_q;
  logic [7:0] byte_q;
  logic       trigger;

  assign trigger = cpu_we && (cpu_address == DMA_REG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      index  <= 8'h00;
      src_q  <= 8'h00;
      byte_q <= 8'h00;
    end else begin
      state <= state_next;
      if (trigger) begin
        src_q <= remap_page(cpu_wdata);
      end
      case (state)
        START: index <= 8'h00;
        LATCH: byte_q <= mem_rdata;
        WRITE: begin
          if (index != LAST_INDEX) begin
            index <= index + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = IDLE;
      START:   state_next = READ;
      READ:    state_next = LATCH;
      LATCH:   state_next = WRITE;
      WRITE:   state_next = (index == LAST_INDEX) ? IDLE : READ;
      default: state_next = IDLE;
    endcase
    // A trigger restarts from any state, abandoning the old source page.
    if (trigger) begin
      state_next = START;
    end
  end

  always_comb begin
    mem_address = 16'h0000;
    mem_wdata   = 8'h00;
    mem_oe      = 1'b0;
    mem_we      = 1'b0;
    cpu_blocked = 1'b0;
    case (state)
      IDLE: begin
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        mem_oe      = cpu_oe;
        mem_we      = cpu_we;
      end
      READ: begin
        mem_address = {src_q, index};
        mem_oe      = 1'b1;
      end
      WRITE: begin
        mem_address = OAM_BASE + {8'h00, index};
        mem_wdata   = byte_q;
        mem_we      = 1'b1;
      end
      default: ;
    endcase
    if (state != IDLE) begin
      cpu_blocked = cpu_oe | cpu_we;
    end
  end

  assign dma_active = (state != IDLE);
  assign dma_index  = index;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a registered-read memory model.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_wdata;
  logic        cpu_oe;
  logic        cpu_we;
  logic [7:0]  mem_rdata;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_oe;
  logic        mem_we;
  logic        cpu_blocked;
  logic        dma_active;
  logic [7:0]  dma_index;

  logic [7:0] mem [0:65535];
  int checks = 0;
  int errors = 0;

  oam_dma_controller dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_address (cpu_address),
    .cpu_wdata   (cpu_wdata),
    .cpu_oe      (cpu_oe),
    .cpu_we      (cpu_we),
    .mem_rdata   (mem_rdata),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_oe      (mem_oe),
    .mem_we      (mem_we),
    .cpu_blocked (cpu_blocked),
    .dma_active  (dma_active),
    .dma_index   (dma_index)
  );

  always #5 clk = ~clk;

  // memoryunit stand-in: write on the edge, read data valid the next cycle
  always @(posedge clk) begin
    if (mem_we) mem[mem_address] <= mem_wdata;
    mem_rdata <= mem[mem_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cpu_idle();
    cpu_address = 16'h0000;
    cpu_wdata   = 8'h00;
    cpu_oe      = 1'b0;
    cpu_we      = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a;
    cpu_wdata   = d;
    cpu_oe      = 1'b0;
    cpu_we      = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dma_active === 1'b1 && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (dma_active !== 1'b0) begin
      errors++;
      $display("FAIL %s_timeout dma_active got %0b want 0", name, dma_active);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cpu_write(16'hFF46, 8'hC0);
    step();
    step();
    settle();
    checks++;
    if ({dma_active, cpu_blocked, dma_index} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state got %b want 0", {dma_active, cpu_blocked, dma_index});
    end
    cpu_idle();
    cpu_address = 16'h1234;
    cpu_oe = 1'b1;
    settle();
    checks++;
    if ({mem_oe, mem_we, mem_address} !== {1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL reset_passthru got %b %b %h want 1 0 1234", mem_oe, mem_we, mem_address);
    end
    rst = 1'b0;
    cpu_idle();
    step();
    settle();
    checks++;
    if (dma_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_priority dma_active got %0b want 0", dma_active);
    end
  endtask

  task automatic test_idle_passthrough();
    cpu_write(16'hFF80, 8'h12);
    settle();
    checks++;
    if ({mem_we, mem_oe, mem_address, mem_wdata, cpu_blocked} !== {1'b1, 1'b0, 16'hFF80, 8'h12, 1'b0}) begin
      errors++;
      $display("FAIL idle_passthru got we=%b oe=%b a=%h d=%h blk=%b want 1 0 ff80 12 0",
               mem_we, mem_oe, mem_address, mem_wdata, cpu_blocked);
    end
    step();
    cpu_idle();
    settle();
    checks++;
    if (mem[16'hFF80] !== 8'h12) begin
      errors++;
      $display("FAIL idle_write_stored got %h want 12", mem[16'hFF80]);
    end
  endtask

  task automatic test_basic_transfer();
    int k, i, ph;
    for (int j = 0; j < 160; j++) begin
      mem[16'hC000 + 16'(j)] <= 8'(j) ^ 8'h5A;
      mem[16'hFE00 + 16'(j)] <= 8'hFF;
    end
    step();
    cpu_write(16'hFF46, 8'hC0);
    settle();
    checks++;
    if ({mem_we, mem_address, mem_wdata, dma_active} !== {1'b1, 16'hFF46, 8'hC0, 1'b0}) begin
      errors++;
      $display("FAIL trigger_passthru got we=%b a=%h d=%h act=%b want 1 ff46 c0 0",
               mem_we, mem_address, mem_wdata, dma_active);
    end
    for (int c = 1; c <= 482; c++) begin
      step();
      cpu_idle();
      if (c == 100) begin
        cpu_oe = 1'b1;
        cpu_address = 16'hC000;
      end
      if (c == 150) cpu_write(16'hC010, 8'hAA);
      settle();
      checks++;
      if (dma_active !== (c <= 481)) begin
        errors++;
        $display("FAIL basic_active cycle %0d got %0b want %0b", c, dma_active, (c <= 481));
      end
      if (c >= 2 && c <= 481) begin
        k = c - 2;
        i = k / 3;
        ph = k % 3;
        checks++;
        if (ph == 0 && {mem_oe, mem_we, mem_address, dma_index} !== {1'b1, 1'b0, 16'hC000 + 16'(i), 8'(i)}) begin
          errors++;
          $display("FAIL basic_read cycle %0d got oe=%b we=%b a=%h idx=%0d want 1 0 %h %0d",
                   c, mem_oe, mem_we, mem_address, dma_index, 16'hC000 + 16'(i), i);
        end else if (ph == 1 && {mem_oe, mem_we} !== 2'b00) begin
          errors++;
          $display("FAIL basic_latch cycle %0d got oe=%b we=%b want 0 0", c, mem_oe, mem_we);
        end else if (ph == 2 && {mem_oe, mem_we, mem_address, mem_wdata} !== {1'b0, 1'b1, 16'hFE00 + 16'(i), 8'(i) ^ 8'h5A}) begin
          errors++;
          $display("FAIL basic_write cycle %0d got oe=%b we=%b a=%h d=%h want 0 1 %h %h",
                   c, mem_oe, mem_we, mem_address, mem_wdata, 16'hFE00 + 16'(i), 8'(i) ^ 8'h5A);
        end
      end
      if (c == 100) begin
        checks++;
        if ({cpu_blocked, mem_address} !== {1'b1, 16'hFE20}) begin
          errors++;
          $display("FAIL block_read got blk=%b a=%h want 1 fe20", cpu_blocked, mem_address);
        end
      end
      if (c == 150) begin
        checks++;
        if ({cpu_blocked, mem_we} !== 2'b10) begin
          errors++;
          $display("FAIL block_write got blk=%b we=%b want 1 0", cpu_blocked, mem_we);
        end
      end
    end
    cpu_idle();
    for (int j = 0; j < 160; j++) begin
      checks++;
      if (mem[16'hFE00 + 16'(j)] !== (8'(j) ^ 8'h5A)) begin
        errors++;
        $display("FAIL basic_oam[%0d] got %h want %h", j, mem[16'hFE00 + 16'(j)], 8'(j) ^ 8'h5A);
      end
    end
    checks++;
    if (mem[16'hC010] !== 8'h4A) begin
      errors++;
      $display("FAIL blocked_write_dropped got %h want 4a", mem[16'hC010]);
    end
    checks++;
    if (mem[16'hFF46] !== 8'hC0) begin
      errors++;
      $display("FAIL io_reg_stored got %h want c0", mem[16'hFF46]);
    end
  endtask

  task automatic test_restart();
    for (int j = 0; j < 160; j++) mem[16'hC100 + 16'(j)] <= 8'(j) ^ 8'hA5;
    step();
    cpu_write(16'hFF46, 8'hC0);
    for (int c = 1; c <= 532; c++) begin
      step();
      cpu_idle();
      if (c == 50) cpu_write(16'hFF46, 8'hC1);
      settle();
      if (c == 50) begin
        checks++;
        if ({mem_oe, mem_we, mem_address} !== {1'b1, 1'b0, 16'hC010}) begin
          errors++;
          $display("FAIL restart_trigger_cycle got oe=%b we=%b a=%h want 1 0 c010", mem_oe, mem_we, mem_address);
        end
      end
      if (c == 51) begin
        checks++;
        if ({dma_active, mem_oe, mem_we} !== 3'b100) begin
          errors++;
          $display("FAIL restart_start got %b want 100", {dma_active, mem_oe, mem_we});
        end
      end
      if (c == 52) begin
        checks++;
        if ({mem_oe, mem_address, dma_index} !== {1'b1, 16'hC100, 8'h00}) begin
          errors++;
          $display("FAIL restart_first_read got oe=%b a=%h idx=%0d want 1 c100 0", mem_oe, mem_address, dma_index);
        end
      end
      if (c == 531 || c == 532) begin
        checks++;
        if (dma_active !== (c == 531)) begin
          errors++;
          $display("FAIL restart_active cycle %0d got %0b want %0b", c, dma_active, (c == 531));
        end
      end
    end
    for (int j = 0; j < 160; j++) begin
      checks++;
      if (mem[16'hFE00 + 16'(j)] !== (8'(j) ^ 8'hA5)) begin
        errors++;
        $display("FAIL restart_oam[%0d] got %h want %h", j, mem[16'hFE00 + 16'(j)], 8'(j) ^ 8'hA5);
      end
    end
    checks++;
    if (mem[16'hFF46] !== 8'hC0) begin
      errors++;
      $display("FAIL restart_io_reg got %h want c0", mem[16'hFF46]);
    end
  endtask

  task automatic test_remap();
    cpu_write(16'hFF46, 8'hE0);
    step();
    cpu_idle();
    step();
    settle();
    checks++;
    if ({mem_oe, mem_address} !== {1'b1, 16'hC000}) begin
      errors++;
      $display("FAIL remap_read0 got oe=%b a=%h want 1 c000", mem_oe, mem_address);
    end
    step();
    step();
    step();
    settle();
    checks++;
    if ({mem_oe, mem_address} !== {1'b1, 16'hC001}) begin
      errors++;
      $display("FAIL remap_read1 got oe=%b a=%h want 1 c001", mem_oe, mem_address);
    end
    wait_idle("remap");
    for (int j = 0; j < 160; j++) begin
      checks++;
      if (mem[16'hFE00 + 16'(j)] !== (8'(j) ^ 8'h5A)) begin
        errors++;
        $display("FAIL remap_oam[%0d] got %h want %h", j, mem[16'hFE00 + 16'(j)], 8'(j) ^ 8'h5A);
      end
    end
    checks++;
    if (mem[16'hFF46] !== 8'hE0) begin
      errors++;
      $display("FAIL remap_io_reg got %h want e0", mem[16'hFF46]);
    end
    // 0xDF sits just below the echo range and must not be folded
    cpu_write(16'hFF46, 8'hDF);
    step();
    cpu_idle();
    step();
    settle();
    checks++;
    if ({mem_oe, mem_address} !== {1'b1, 16'hDF00}) begin
      errors++;
      $display("FAIL no_remap_df got oe=%b a=%h want 1 df00", mem_oe, mem_address);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    checks++;
    if (dma_active !== 1'b0) begin
      errors++;
      $display("FAIL remap_abort got %0b want 0", dma_active);
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 160; j++) mem[16'hFE00 + 16'(j)] <= 8'hEE;
    step();
    cpu_write(16'hFF46, 8'hC1);
    for (int c = 1; c <= 200; c++) begin
      step();
      cpu_idle();
    end
    rst = 1'b1;
    settle();
    checks++;
    if ({mem_oe, mem_address} !== {1'b1, 16'hC142}) begin
      errors++;
      $display("FAIL resetmid_cycle200 got oe=%b a=%h want 1 c142", mem_oe, mem_address);
    end
    step();
    rst = 1'b0;
    cpu_address = 16'h1234;
    cpu_oe = 1'b1;
    settle();
    checks++;
    if ({dma_active, dma_index, mem_oe, mem_we, mem_address} !== {1'b0, 8'h00, 1'b1, 1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL resetmid_idle got act=%b idx=%0d oe=%b we=%b a=%h want 0 0 1 0 1234",
               dma_active, dma_index, mem_oe, mem_we, mem_address);
    end
    cpu_idle();
    step();
    for (int j = 0; j < 160; j++) begin
      checks++;
      if (mem[16'hFE00 + 16'(j)] !== ((j <= 65) ? (8'(j) ^ 8'hA5) : 8'hEE)) begin
        errors++;
        $display("FAIL resetmid_oam[%0d] got %h want %h", j, mem[16'hFE00 + 16'(j)],
                 (j <= 65) ? (8'(j) ^ 8'hA5) : 8'hEE);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_idle();
    test_reset();
    test_idle_passthrough();
    test_basic_transfer();
    test_restart();
    test_remap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
